sa_axi4_mem_slave: RTL

- AXI4-Full slave responder modelling the off-chip memory that the systolic array's AXI4 master loads from and stores to.
- 128-bit data bus, INCR/FIXED bursts, up to 256 beats per burst, byte strobes, ID echo.
- Backed by an internal synchronous RAM.
- Used in system-level benches and as an on-fabric scratch memory behind the master port.
- Independent write channel FSM and read channel FSM; one outstanding transaction per direction.

---
 rtl/sa_axi4_mem_slave.sv | 231 +++++++++++++++++++++++
 1 files changed

// File: rtl/sa_axi4_mem_slave.sv
// AXI4-Full slave backed by a synchronous RAM: 128-bit beats, INCR/FIXED bursts,
// byte strobes, ID echo, one outstanding transaction per direction.
module sa_axi4_mem_slave #(
  parameter int unsigned           ID_WIDTH   = 1,
  parameter int unsigned           ADDR_WIDTH = 32,
  parameter int unsigned           DATA_WIDTH = 128,
  parameter int unsigned           MEM_DEPTH  = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 32'h4000_0000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready
);

  localparam int unsigned WordBits = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] MemBytes = ADDR_WIDTH'(MEM_DEPTH * 16);
  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;
  localparam logic [1:0] RespDecerr = 2'b11;

  typedef logic [WordBits-1:0] word_t;
  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [1:0] {RIdle, RFetch, RData} r_state_e;

  function automatic logic [1:0] classify(input logic [ADDR_WIDTH-1:0] addr,
                                          input logic [2:0] size, input logic [1:0] burst);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    if (addr < BASE_ADDR || off >= MemBytes) return RespDecerr;
    if (size != 3'd4 || burst == 2'b10) return RespSlverr;
    return RespOkay;
  endfunction

  // Word index wraps modulo MEM_DEPTH by truncation.
  function automatic word_t word_of(input logic [ADDR_WIDTH-1:0] addr);
    logic [ADDR_WIDTH-1:0] off;
    off = addr - BASE_ADDR;
    return word_t'(off >> 4);
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [DATA_WIDTH-1:0] ram_q;
  logic                  mem_we, rd_en;
  word_t                 rd_addr;

  // Write channel state
  w_state_e            w_state_q, w_state_d;
  logic [ID_WIDTH-1:0] w_id_q, w_id_d;
  word_t               w_word_q, w_word_d;
  logic [7:0]          w_len_q, w_len_d, w_beat_q, w_beat_d;
  logic                w_incr_q, w_incr_d;
  logic [1:0]          w_err_q, w_err_d;

  // Read channel state
  r_state_e            r_state_q, r_state_d;
  logic [ID_WIDTH-1:0] r_id_q, r_id_d;
  word_t               r_word_q, r_word_d, r_word_nxt;
  logic [7:0]          r_len_q, r_len_d, r_beat_q, r_beat_d;
  logic                r_incr_q, r_incr_d;
  logic [1:0]          r_err_q, r_err_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state_q <= WIdle;
      w_id_q    <= '0;
      w_word_q  <= '0;
      w_len_q   <= '0;
      w_beat_q  <= '0;
      w_incr_q  <= 1'b0;
      w_err_q   <= RespOkay;
      r_state_q <= RIdle;
      r_id_q    <= '0;
      r_word_q  <= '0;
      r_len_q   <= '0;
      r_beat_q  <= '0;
      r_incr_q  <= 1'b0;
      r_err_q   <= RespOkay;
    end else begin
      w_state_q <= w_state_d;
      w_id_q    <= w_id_d;
      w_word_q  <= w_word_d;
      w_len_q   <= w_len_d;
      w_beat_q  <= w_beat_d;
      w_incr_q  <= w_incr_d;
      w_err_q   <= w_err_d;
      r_state_q <= r_state_d;
      r_id_q    <= r_id_d;
      r_word_q  <= r_word_d;
      r_len_q   <= r_len_d;
      r_beat_q  <= r_beat_d;
      r_incr_q  <= r_incr_d;
      r_err_q   <= r_err_d;
    end
  end

  // Read-first RAM: a same-cycle write is seen by the next read only.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < DATA_WIDTH / 8; i++) begin
        if (s_axi_wstrb[i]) mem[w_word_q][8*i +: 8] <= s_axi_wdata[8*i +: 8];
      end
    end
    if (rd_en) ram_q <= mem[rd_addr];
  end

  always_comb begin
    w_state_d = w_state_q;
    w_id_d    = w_id_q;
    w_word_d  = w_word_q;
    w_len_d   = w_len_q;
    w_beat_d  = w_beat_q;
    w_incr_d  = w_incr_q;
    w_err_d   = w_err_q;
    mem_we    = 1'b0;
    unique case (w_state_q)
      WIdle: begin
        if (s_axi_awvalid && s_axi_awready) begin
          w_id_d    = s_axi_awid;
          w_word_d  = word_of(s_axi_awaddr);
          w_len_d   = s_axi_awlen;
          w_beat_d  = '0;
          w_incr_d  = (s_axi_awburst == 2'b01);
          w_err_d   = classify(s_axi_awaddr, s_axi_awsize, s_axi_awburst);
          w_state_d = WData;
        end
      end
      WData: begin
        if (s_axi_wvalid && s_axi_wready) begin
          mem_we   = (w_err_q == RespOkay) && !reset;
          w_beat_d = w_beat_q + 8'd1;
          if (w_incr_q) w_word_d = w_word_q + word_t'(1);
          // A wlast mismatch only downgrades OKAY; a decode error is kept.
          if ((s_axi_wlast != (w_beat_q == w_len_q)) && w_err_q == RespOkay) begin
            w_err_d = RespSlverr;
          end
          if (w_beat_q == w_len_q) w_state_d = WResp;
        end
      end
      WResp: begin
        if (s_axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  assign r_word_nxt = r_incr_q ? r_word_q + word_t'(1) : r_word_q;

  always_comb begin
    r_state_d = r_state_q;
    r_id_d    = r_id_q;
    r_word_d  = r_word_q;
    r_len_d   = r_len_q;
    r_beat_d  = r_beat_q;
    r_incr_d  = r_incr_q;
    r_err_d   = r_err_q;
    rd_en     = 1'b0;
    rd_addr   = r_word_q;
    unique case (r_state_q)
      RIdle: begin
        if (s_axi_arvalid && s_axi_arready) begin
          r_id_d    = s_axi_arid;
          r_word_d  = word_of(s_axi_araddr);
          r_len_d   = s_axi_arlen;
          r_beat_d  = '0;
          r_incr_d  = (s_axi_arburst == 2'b01);
          r_err_d   = classify(s_axi_araddr, s_axi_arsize, s_axi_arburst);
          rd_en     = 1'b1;
          rd_addr   = word_of(s_axi_araddr);
          r_state_d = RFetch;
        end
      end
      RFetch: r_state_d = RData;
      RData: begin
        if (s_axi_rready) begin
          if (r_beat_q == r_len_q) begin
            r_state_d = RIdle;
          end else begin
            // Prefetch the next beat so rready held high gives one beat per cycle.
            r_beat_d = r_beat_q + 8'd1;
            r_word_d = r_word_nxt;
            rd_en    = 1'b1;
            rd_addr  = r_word_nxt;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  assign s_axi_awready = (w_state_q == WIdle) && !reset;
  assign s_axi_wready  = (w_state_q == WData) && !reset;
  assign s_axi_bvalid  = (w_state_q == WResp);
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = s_axi_bvalid ? w_err_q : RespOkay;

  assign s_axi_arready = (r_state_q == RIdle) && !reset;
  assign s_axi_rvalid  = (r_state_q == RData);
  assign s_axi_rid     = r_id_q;
  assign s_axi_rresp   = s_axi_rvalid ? r_err_q : RespOkay;
  assign s_axi_rlast   = s_axi_rvalid && (r_beat_q == r_len_q);
  assign s_axi_rdata   = (s_axi_rvalid && r_err_q == RespOkay) ? ram_q : '0;

endmodule
